sys_bus_lrs_scheduler: RTL and testbench
========================================

// Module: sys_bus_lrs_scheduler
// PURPOSE
//  Arbitrates the shared L1<->L2 system bus among the 4 L1 cache cores.
//  Grants one processor-side owner at a time, in least-recently-served (LRS) order.
//  Within an ownership window it sequences snoop grants (other cores) and the L2 grant.
//  Optional watchdog flags owners that hold the bus too long.
//  Sits between cache_top req/gnt ports and the system bus interface.
// PARAMETERS
//  NUM_CORES    4    requester count; only 4 is supported, core IDs are 2 bits
//  TIMEOUT_CYC  90   maximum proc-grant hold cycles before timeout (watchdog only)
//  CNT_WID      8    watchdog counter width; TIMEOUT_CYC < 2**CNT_WID
// PORTS
//  clk                    in   1  system clock, all state updates on posedge
//  rst_n                  in   1  asynchronous active-low reset
//  bus_lv1_lv2_req_proc   in   4  per-core processor-side bus request
//  bus_lv1_lv2_gnt_proc   out  4  per-core processor grant, onehot0
//  bus_lv1_lv2_req_snoop  in   4  per-core snoop request
//  bus_lv1_lv2_gnt_snoop  out  4  per-core snoop grant, onehot0
//  bus_lv1_lv2_req_lv2    in   1  L2 request to drive the data bus
//  bus_lv1_lv2_gnt_lv2    out  1  L2 grant
//  owner_id               out  2  core ID of current proc owner; valid while gnt_proc!=0
//  timeout_err            out  1  sticky watchdog error
//  timeout_core           out  2  owner ID captured at the first timeout
// BEHAVIOUR
//  Reset: all grants 0; owner_id 0; timeout_err 0; timeout_core 0; FSM IDLE.
//   LRS queue = {0,1,2,3}, core0 most eligible. Reset is async and may occur mid-ownership.
//  All outputs are registered. A request sampled at edge N gives its grant after edge N (1-cycle latency).
//  FSM states: IDLE, OWN, SNOOP, LV2, RELEASE.
//   IDLE: if any req_proc, pick the first requesting core in the LRS queue.
//    Set gnt_proc[id] and owner_id, then go to OWN. Otherwise stay in IDLE.
//   OWN: if req_proc[owner] is 0, drop gnt_proc and go to RELEASE.
//    Else if any req_snoop excluding the owner, grant the first such core in LRS order and go to SNOOP.
//    Else if req_lv2, set gnt_lv2 and go to LV2.
//   SNOOP: hold gnt_snoop while that core's req_snoop is 1.
//    When it drops, clear the snoop grant and return to OWN. No other snoop is granted in the same cycle.
//   LV2: hold gnt_lv2 while req_lv2 is 1; on drop, clear gnt_lv2 and return to OWN.
//   RELEASE: one dead cycle with all grants 0. Move the served core to the LRS tail and go to IDLE.
//  Priority inside OWN: snoop beats lv2 when both are requested in the same cycle.
//  gnt_proc stays held throughout SNOOP and LV2.
//  Owner drops req_proc during SNOOP or LV2: finish the sub-grant first, then go OWN -> RELEASE.
//  A snoop request from the owner itself is ignored.
//  Invariants:
//   - gnt_proc and gnt_snoop are each onehot0.
//   - gnt_snoop and gnt_lv2 are never both 1.
//   - gnt_snoop[owner] is never set.
//   - No grant is ever given to a core whose request is 0.
//  Fairness: with all 4 requesting continuously, grant order is a rotation.
//   Worst-case wait is 3 ownerships.
// CONFIGURATION
//  SYS_BUS_ARB_WDT_EN defined:
//   - A CNT_WID counter clears on entry to OWN and increments each cycle gnt_proc is held. It saturates.
//   - When the count reaches TIMEOUT_CYC, timeout_err is set and timeout_core captures owner_id. Both are sticky until reset.
//   - On timeout, the owner's grant is NOT revoked. The flag is diagnostic only.
//  SYS_BUS_ARB_WDT_EN not defined:
//   - No counter logic is built; timeout_err and timeout_core are tied to 0.
// TESTING
//  1) Reset, then req_proc=4'b0100 held 5 cycles, then dropped.
//     -> gnt_proc=4'b0100 one cycle after sampling, owner_id=2; grant clears 1 cycle after drop.
//     -> One dead cycle follows; LRS queue becomes {0,1,3,2}.
//  2) req_proc=4'b1111 held, each owner drops req 3 cycles after its grant, then re-requests.
//     -> Grant order is 0,1,2,3,0; gnt_proc onehot0 every cycle; 1 idle cycle between owners.
//  3) Owner=1, then req_snoop=4'b1011 and req_lv2=1 in the same cycle.
//     -> gnt_snoop=4'b0001 first, gnt_lv2 stays 0. Core1's snoop request is never granted.
//     -> After core0 drops snoop, core3 is granted a snoop; gnt_lv2 only after all snoops clear.
//  4) Owner=3 in LV2, then rst_n=0 mid-cycle.
//     -> All grants 0 immediately (async). After release, req_proc=4'b1001 -> core0 is granted.
//  5) With SYS_BUS_ARB_WDT_EN, TIMEOUT_CYC=90, core2 holds req_proc 100 cycles.
//     -> timeout_err=1 on the 90th held cycle, timeout_core=2, gnt_proc unchanged.
//     -> Without the macro, timeout_err stays 0.

Source files
------------

// File: rtl/sys_bus_lrs_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sys_bus_lrs_scheduler
// Desc    : Least-recently-served arbiter for the shared L1<->L2 system bus,
//           sequencing snoop and L2 sub-grants inside each ownership window.
//           Optional watchdog is built when SYS_BUS_ARB_WDT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module sys_bus_lrs_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int TIMEOUT_CYC = 90,
  parameter int CNT_WID     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc,
  output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc,
  input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop,
  input  logic                 bus_lv1_lv2_req_lv2,
  output logic                 bus_lv1_lv2_gnt_lv2,
  output logic [1:0]           owner_id,
  output logic                 timeout_err,
  output logic [1:0]           timeout_core
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OWN     = 3'd1,
    S_SNOOP   = 3'd2,
    S_LV2     = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_CORES-1:0]   gnt_proc_nxt, gnt_snoop_nxt;
  logic                   gnt_lv2_nxt;
  logic [1:0]             owner_nxt, snoop_id, snoop_id_nxt;
  logic [1:0]             lrs_q     [NUM_CORES];
  logic [1:0]             lrs_q_nxt [NUM_CORES];
  logic [1:0]             lrs_rot   [NUM_CORES];
  logic [1:0]             rel_pos;
  logic [NUM_CORES-1:0]   snoop_cand;
  logic                   proc_hit, snoop_hit;
  logic [1:0]             proc_pick, snoop_pick;

  // The owner's own snoop request never competes for a snoop grant.
  assign snoop_cand = bus_lv1_lv2_req_snoop & ~(NUM_CORES'(1) << owner_id);

  // Scan the LRS queue from the tail so the head-most match wins.
  always_comb begin
    proc_hit   = 1'b0;
    proc_pick  = '0;
    snoop_hit  = 1'b0;
    snoop_pick = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (bus_lv1_lv2_req_proc[lrs_q[i]]) begin
        proc_hit  = 1'b1;
        proc_pick = lrs_q[i];
      end
      if (snoop_cand[lrs_q[i]]) begin
        snoop_hit  = 1'b1;
        snoop_pick = lrs_q[i];
      end
    end
  end

  always_comb begin
    rel_pos = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (lrs_q[i] == owner_id) rel_pos = 2'(i);
    end
    for (int i = 0; i < NUM_CORES-1; i++) begin
      lrs_rot[i] = (2'(i) >= rel_pos) ? lrs_q[i+1] : lrs_q[i];
    end
    lrs_rot[NUM_CORES-1] = owner_id;
  end

  always_comb begin
    state_nxt     = state;
    gnt_proc_nxt  = bus_lv1_lv2_gnt_proc;
    gnt_snoop_nxt = bus_lv1_lv2_gnt_snoop;
    gnt_lv2_nxt   = bus_lv1_lv2_gnt_lv2;
    owner_nxt     = owner_id;
    snoop_id_nxt  = snoop_id;
    lrs_q_nxt     = lrs_q;
    case (state)
      S_IDLE: begin
        if (proc_hit) begin
          gnt_proc_nxt = NUM_CORES'(1) << proc_pick;
          owner_nxt    = proc_pick;
          state_nxt    = S_OWN;
        end
      end
      S_OWN: begin
        if (!bus_lv1_lv2_req_proc[owner_id]) begin
          gnt_proc_nxt = '0;
          state_nxt    = S_RELEASE;
        end else if (snoop_hit) begin
          gnt_snoop_nxt = NUM_CORES'(1) << snoop_pick;
          snoop_id_nxt  = snoop_pick;
          state_nxt     = S_SNOOP;
        end else if (bus_lv1_lv2_req_lv2) begin
          gnt_lv2_nxt = 1'b1;
          state_nxt   = S_LV2;
        end
      end
      S_SNOOP: begin
        if (!bus_lv1_lv2_req_snoop[snoop_id]) begin
          gnt_snoop_nxt = '0;
          state_nxt     = S_OWN;
        end
      end
      S_LV2: begin
        if (!bus_lv1_lv2_req_lv2) begin
          gnt_lv2_nxt = 1'b0;
          state_nxt   = S_OWN;
        end
      end
      S_RELEASE: begin
        lrs_q_nxt = lrs_rot;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      bus_lv1_lv2_gnt_proc  <= '0;
      bus_lv1_lv2_gnt_snoop <= '0;
      bus_lv1_lv2_gnt_lv2   <= 1'b0;
      owner_id              <= '0;
      snoop_id              <= '0;
      for (int i = 0; i < NUM_CORES; i++) lrs_q[i] <= 2'(i);
    end else begin
      state                 <= state_nxt;
      bus_lv1_lv2_gnt_proc  <= gnt_proc_nxt;
      bus_lv1_lv2_gnt_snoop <= gnt_snoop_nxt;
      bus_lv1_lv2_gnt_lv2   <= gnt_lv2_nxt;
      owner_id              <= owner_nxt;
      snoop_id              <= snoop_id_nxt;
      lrs_q                 <= lrs_q_nxt;
    end
  end

`ifdef SYS_BUS_ARB_WDT_EN
  logic [CNT_WID-1:0] wdt_cnt;

  // Count restarts with each new ownership; the flag is diagnostic, grants are untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt      <= '0;
      timeout_err  <= 1'b0;
      timeout_core <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_OWN) begin
        wdt_cnt <= '0;
      end else if (|bus_lv1_lv2_gnt_proc && wdt_cnt != '1) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      if (|bus_lv1_lv2_gnt_proc && !timeout_err && wdt_cnt == CNT_WID'(TIMEOUT_CYC - 1)) begin
        timeout_err  <= 1'b1;
        timeout_core <= owner_id;
      end
    end
  end
`else
  assign timeout_err  = 1'b0;
  assign timeout_core = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_lrs_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sys_bus_lrs_scheduler
// Desc    : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sys_bus_lrs_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_proc = '0, req_snoop = '0;
  logic       req_lv2 = 1'b0;
  logic [3:0] gnt_proc, gnt_snoop;
  logic       gnt_lv2, timeout_err;
  logic [1:0] owner_id, timeout_core;

  int checks = 0;
  int errors = 0;

  sys_bus_lrs_scheduler #(.NUM_CORES(4), .TIMEOUT_CYC(90), .CNT_WID(8)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus_lv1_lv2_req_proc  (req_proc),
    .bus_lv1_lv2_gnt_proc  (gnt_proc),
    .bus_lv1_lv2_req_snoop (req_snoop),
    .bus_lv1_lv2_gnt_snoop (gnt_snoop),
    .bus_lv1_lv2_req_lv2   (req_lv2),
    .bus_lv1_lv2_gnt_lv2   (gnt_lv2),
    .owner_id              (owner_id),
    .timeout_err           (timeout_err),
    .timeout_core          (timeout_core)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rp;
    logic [3:0] rs;
    logic       rl;
    logic [3:0] gp;
    logic [3:0] gs;
    logic       gl;
    logic [1:0] own;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_proc  = '0;
    req_snoop = '0;
    req_lv2   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: holder = core owning the bus (-1 none), sub = active
  // sub-grant (0..3 snoop core, 4 = L2, -1 none), dead = core being retired.
  int m_lrs[$];
  int m_holder, m_dead, m_sub, m_last;

  function automatic void m_reset();
    m_lrs    = {0, 1, 2, 3};
    m_holder = -1;
    m_dead   = -1;
    m_sub    = -1;
    m_last   = 0;
  endfunction

  function automatic void m_step(input logic [3:0] rp, input logic [3:0] rs, input logic rl);
    int pick;
    int idx;
    pick = -1;
    idx  = 0;
    if (m_dead >= 0) begin
      for (int i = 0; i < m_lrs.size(); i++) if (m_lrs[i] == m_dead) idx = i;
      m_lrs.delete(idx);
      m_lrs.push_back(m_dead);
      m_dead = -1;
    end else if (m_holder < 0) begin
      for (int i = 0; i < m_lrs.size(); i++) if (pick < 0 && rp[m_lrs[i]]) pick = m_lrs[i];
      if (pick >= 0) begin
        m_holder = pick;
        m_last   = pick;
      end
    end else if (m_sub == 4) begin
      if (!rl) m_sub = -1;
    end else if (m_sub >= 0) begin
      if (!rs[m_sub]) m_sub = -1;
    end else if (!rp[m_holder]) begin
      m_dead   = m_holder;
      m_holder = -1;
    end else begin
      for (int i = 0; i < m_lrs.size(); i++)
        if (pick < 0 && m_lrs[i] != m_holder && rs[m_lrs[i]]) pick = m_lrs[i];
      if (pick >= 0) m_sub = pick;
      else if (rl) m_sub = 4;
    end
  endfunction

  function automatic logic [10:0] m_expected();
    logic [3:0] gp, gs;
    gp = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0;
    gs = (m_sub >= 0 && m_sub < 4) ? 4'(1 << m_sub) : 4'b0;
    return {gp, gs, 1'(m_sub == 4), 2'(m_last)};
  endfunction

  vec_t vecs[12];

  initial begin
    // Snoop-vs-L2 ordering with owner=1 and owner's own snoop ignored.
    vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1};
    vecs[1]  = '{4'b0010, 4'b1011, 1'b1, 4'b0010, 4'b0001, 1'b0, 2'd1};
    vecs[2]  = '{4'b0010, 4'b1011, 1'b1, 4'b0010, 4'b0001, 1'b0, 2'd1};
    vecs[3]  = '{4'b0010, 4'b1010, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd1};
    vecs[4]  = '{4'b0010, 4'b1010, 1'b1, 4'b0010, 4'b1000, 1'b0, 2'd1};
    vecs[5]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd1};
    vecs[6]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'd1};
    vecs[7]  = '{4'b0000, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1};
    vecs[10] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1};
    vecs[11] = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0};

    // Reset state
    do_reset();
    check("reset_outputs", {gnt_proc, gnt_snoop, gnt_lv2, owner_id, timeout_err, timeout_core},
          {4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 2'd0});

    // Single requester, then verify it moved to the LRS tail
    req_proc = 4'b0100;
    tick();
    check("t1_grant", {gnt_proc, owner_id}, {4'b0100, 2'd2});
    repeat (4) tick();
    check("t1_held", gnt_proc, 4'b0100);
    req_proc = 4'b0000;
    tick();
    check("t1_drop", gnt_proc, 4'b0000);
    tick();
    check("t1_dead", {gnt_proc, gnt_snoop, gnt_lv2}, 9'b0);
    req_proc = 4'b1100;
    tick();
    check("t1_lrs_tail", {gnt_proc, owner_id}, {4'b1000, 2'd3});

    // Snoop/L2 sequencing table
    do_reset();
    foreach (vecs[i]) begin
      req_proc  = vecs[i].rp;
      req_snoop = vecs[i].rs;
      req_lv2   = vecs[i].rl;
      tick();
      check($sformatf("vec%0d", i), {gnt_proc, gnt_snoop, gnt_lv2, owner_id},
            {vecs[i].gp, vecs[i].gs, vecs[i].gl, vecs[i].own});
    end

    // Rotation with all four requesting
    do_reset();
    req_proc = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int waited;
      int zeros;
      waited = 0;
      zeros  = 0;
      tick();
      while (gnt_proc == 4'b0 && waited < 10) begin
        zeros++;
        waited++;
        tick();
      end
      check($sformatf("rot%0d_order", n), {gnt_proc, owner_id}, {4'(1 << (n % 4)), 2'(n % 4)});
      if (n > 0) check($sformatf("rot%0d_gap", n), 32'(zeros > 0), 32'd1);
      repeat (2) tick();
      check($sformatf("rot%0d_onehot", n), 32'($onehot0(gnt_proc)), 32'd1);
      req_proc = 4'b1111 & ~4'(1 << (n % 4));
      tick();
      check($sformatf("rot%0d_drop", n), gnt_proc, 4'b0);
      req_proc = 4'b1111;
    end

    // Asynchronous reset while owner 3 holds an L2 grant
    do_reset();
    req_proc = 4'b1000;
    tick();
    req_lv2 = 1'b1;
    tick();
    check("t4_in_lv2", {gnt_proc, gnt_lv2, owner_id}, {4'b1000, 1'b1, 2'd3});
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_clear", {gnt_proc, gnt_snoop, gnt_lv2, owner_id}, 11'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    req_lv2  = 1'b0;
    req_proc = 4'b1001;
    tick();
    check("t4_after_reset", {gnt_proc, owner_id}, {4'b0100 >> 2, 2'd0});

    // Long hold: watchdog behaviour depends on build
    do_reset();
    req_proc = 4'b0100;
    tick();
    repeat (79) tick();
    check("t5_no_err_early", timeout_err, 1'b0);
    repeat (15) tick();
`ifdef SYS_BUS_ARB_WDT_EN
    check("t5_err", {timeout_err, timeout_core}, {1'b1, 2'd2});
`else
    check("t5_err_off", {timeout_err, timeout_core}, 3'b0);
`endif
    check("t5_grant_kept", gnt_proc, 4'b0100);
    repeat (5) tick();
    req_proc = 4'b0000;
    repeat (2) tick();

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      req_proc  = req_proc ^ 4'($urandom & $urandom);
      req_snoop = req_snoop ^ 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) req_lv2 = ~req_lv2;
      if (c % 700 == 699) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_async_reset", {gnt_proc, gnt_snoop, gnt_lv2}, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
      end
      @(posedge clk);
      m_step(req_proc, req_snoop, req_lv2);
      #1;
      check("rand_outputs", {gnt_proc, gnt_snoop, gnt_lv2, owner_id}, m_expected());
      check("rand_invariants",
            32'($onehot0(gnt_proc) && $onehot0(gnt_snoop) && !(|gnt_snoop && gnt_lv2) &&
                !(|(gnt_snoop & gnt_proc))), 32'd1);
`ifndef SYS_BUS_ARB_WDT_EN
      if (timeout_err) check("rand_timeout_off", timeout_err, 1'b0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
